// File: rtl/spi_pkg.sv
// Shared SPI frame definitions: 10-bit frames carrying a 2-bit command and an 8-bit payload.
// Used by both the SPI slave and the spi_ram back-end.
package spi_pkg;

   localparam int FRAME_W = 10;
   localparam int DATA_W  = 8;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   function automatic logic [1:0] frame_cmd(input logic [FRAME_W-1:0] f);
      return f[FRAME_W-1:FRAME_W-2];
   endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Raw single-port byte array with a registered, enable-gated read port.
// The read register resets to zero and holds between reads; array contents are never reset.
module spi_ram_mem #(
   parameter int DEPTH = 256,
   parameter int AW    = 8,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/spi_ram.sv
// Frame decoder, address registers and error flag in front of spi_ram_mem.
// Define SPI_RAM_AUTO_INC_EN to post-increment addresses after each accepted data access.
module spi_ram
   import spi_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [FRAME_W-1:0] din,
   input  logic               rx_valid,
   output logic [DATA_W-1:0]  dout,
   output logic               tx_valid,
   output logic               err
);

   localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int CMP_W  = ADDR_SIZE + 1;
   localparam logic [CMP_W-1:0] DEPTH_C = CMP_W'(MEM_DEPTH);

   logic [1:0]           cmd;
   logic [ADDR_SIZE-1:0] payload_addr;
   logic [DATA_W-1:0]    payload_data;
   logic [ADDR_SIZE-1:0] wr_addr, rd_addr, mem_addr;
   logic                 wr_addr_ok, rd_addr_ok;
   logic                 addr_in_range, do_wr, do_rd;

`ifdef SPI_RAM_AUTO_INC_EN
   localparam logic [CMP_W-1:0] LAST_C = CMP_W'(MEM_DEPTH - 1);

   function automatic logic [ADDR_SIZE-1:0] bump(input logic [ADDR_SIZE-1:0] a);
      if ({1'b0, a} == LAST_C) return '0;
      return a + 1'b1;
   endfunction
`endif

   assign cmd           = frame_cmd(din);
   assign payload_addr  = din[ADDR_SIZE-1:0];
   assign payload_data  = din[DATA_W-1:0];
   assign addr_in_range = ({1'b0, payload_addr} < DEPTH_C);

   // Reset wins over a coincident frame, so memory side effects are gated by rst too.
   assign do_wr    = rx_valid && !rst && (cmd == CMD_WR_DATA) && wr_addr_ok;
   assign do_rd    = rx_valid && !rst && (cmd == CMD_RD_DATA) && rd_addr_ok;
   assign mem_addr = (cmd == CMD_WR_DATA) ? wr_addr : rd_addr;

   spi_ram_mem #(
      .DEPTH (MEM_DEPTH),
      .AW    (MEM_AW),
      .DW    (DATA_W)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (do_wr),
      .re    (do_rd),
      .addr  (mem_addr[MEM_AW-1:0]),
      .wdata (payload_data),
      .rdata (dout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_addr    <= '0;
         rd_addr    <= '0;
         wr_addr_ok <= 1'b0;
         rd_addr_ok <= 1'b0;
         tx_valid   <= 1'b0;
         err        <= 1'b0;
      end else begin
         tx_valid <= do_rd;
         if (rx_valid) begin
            case (cmd)
               CMD_WR_ADDR: begin
                  if (addr_in_range) begin
                     wr_addr    <= payload_addr;
                     wr_addr_ok <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end
               CMD_WR_DATA: begin
                  if (!wr_addr_ok) err <= 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
                  else wr_addr <= bump(wr_addr);
`endif
               end
               CMD_RD_ADDR: begin
                  if (addr_in_range) begin
                     rd_addr    <= payload_addr;
                     rd_addr_ok <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end
               default: begin
                  if (!rd_addr_ok) err <= 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
                  else rd_addr <= bump(rd_addr);
`endif
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_ram.sv
// Bench for spi_ram: vector table, hand sequences, sweep and a randomized run against a model.
module tb_spi_ram;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] din = '0;
   logic       rx_valid = 1'b0;
   logic [7:0] dout;
   logic       tx_valid;
   logic       err;

   // Second instance with a shallow array so out-of-range addresses can occur.
   logic       s_rst = 1'b1;
   logic [9:0] s_din = '0;
   logic       s_rx_valid = 1'b0;
   logic [7:0] s_dout;
   logic       s_tx_valid;
   logic       s_err;

   int checks = 0;
   int fails  = 0;

`ifdef SPI_RAM_AUTO_INC_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif
   localparam int DEPTH = 256;

   always #5 clk = ~clk;

   spi_ram dut (
      .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
      .dout(dout), .tx_valid(tx_valid), .err(err)
   );

   spi_ram #(.MEM_DEPTH(128), .ADDR_SIZE(8)) dut_s (
      .clk(clk), .rst(s_rst), .din(s_din), .rx_valid(s_rx_valid),
      .dout(s_dout), .tx_valid(s_tx_valid), .err(s_err)
   );

   // Behavioural model: what the spec says each frame does, in plain arithmetic.
   logic [7:0] m_mem [DEPTH];
   int         m_wa, m_ra;
   bit         m_wok, m_rok, m_err, m_tx;
   logic [7:0] m_dout;

   task automatic model_upd(input logic r, input logic v, input logic [9:0] f);
      int p;
      p = int'(f[7:0]);
      if (r) begin
         m_wa = 0; m_ra = 0; m_wok = 0; m_rok = 0;
         m_err = 0; m_tx = 0; m_dout = 8'h00;
         return;
      end
      m_tx = 0;
      if (!v) return;
      case (f[9:8])
         2'b00: if (p < DEPTH) begin m_wa = p; m_wok = 1; end else m_err = 1;
         2'b01: if (m_wok) begin
                   m_mem[m_wa] = f[7:0];
                   if (AUTO) m_wa = (m_wa + 1) % DEPTH;
                end else m_err = 1;
         2'b10: if (p < DEPTH) begin m_ra = p; m_rok = 1; end else m_err = 1;
         default: if (m_rok) begin
                   m_dout = m_mem[m_ra];
                   m_tx   = 1;
                   if (AUTO) m_ra = (m_ra + 1) % DEPTH;
                end else m_err = 1;
      endcase
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // One cycle on the main DUT; outputs are valid #1 after the edge that samples the frame.
   task automatic step(input logic r, input logic v, input logic [9:0] f);
      @(negedge clk);
      rst = r; rx_valid = v; din = f;
      @(posedge clk);
      #1;
      model_upd(r, v, f);
   endtask

   task automatic s_step(input logic r, input logic v, input logic [9:0] f);
      @(negedge clk);
      s_rst = r; s_rx_valid = v; s_din = f;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       r;
      logic       v;
      logic [9:0] f;
      logic       tx;
      logic [7:0] dout;
      logic       err;
   } vec_t;

   vec_t tbl[16];

   initial begin
      int pulses;
      logic [7:0] exp_a, exp_b, fill;

      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      logic [7:0] exp_a, exp_b;

      // reset, write/read, protocol error with a pre-seeded location 0
      tbl[0]  = '{1'b1, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 10'h005, 1'b0, 8'h00, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 10'h1A5, 1'b0, 8'h00, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 10'h205, 1'b0, 8'h00, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 10'h300, 1'b1, 8'hA5, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 10'h000, 1'b0, 8'hA5, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 10'h000, 1'b0, 8'hA5, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 10'h15C, 1'b0, 8'hA5, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 10'h133, 1'b0, 8'h00, 1'b1};
      tbl[11] = '{1'b0, 1'b1, 10'h300, 1'b0, 8'h00, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b1};
      tbl[13] = '{1'b0, 1'b1, 10'h200, 1'b0, 8'h00, 1'b1};
      tbl[14] = '{1'b0, 1'b1, 10'h300, 1'b1, 8'h5C, 1'b1};
      tbl[15] = '{1'b1, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0};

      for (int i = 0; i < 16; i++) begin
         step(tbl[i].r, tbl[i].v, tbl[i].f);
         chk($sformatf("tbl%0d_tx", i),   32'(tx_valid), 32'(tbl[i].tx));
         chk($sformatf("tbl%0d_dout", i), 32'(dout),     32'(tbl[i].dout));
         chk($sformatf("tbl%0d_err", i),  32'(err),      32'(tbl[i].err));
      end

      // auto-increment vs. fixed address with wrap at the top of memory
      exp_a = AUTO ? 8'h11 : 8'h22;
      exp_b = 8'h22;
      step(1'b0, 1'b1, 10'h0FF);
      step(1'b0, 1'b1, 10'h111);
      step(1'b0, 1'b1, 10'h122);
      step(1'b0, 1'b1, 10'h2FF);
      step(1'b0, 1'b1, 10'h300);
      chk("auto_rd0_tx", 32'(tx_valid), 32'd1);
      chk("auto_rd0", 32'(dout), 32'(exp_a));
      step(1'b0, 1'b1, 10'h300);
      chk("auto_rd1_tx", 32'(tx_valid), 32'd1);
      chk("auto_rd1", 32'(dout), 32'(exp_b));
      step(1'b0, 1'b0, 10'h000);
      chk("auto_tx_drop", 32'(tx_valid), 32'd0);
      chk("auto_dout_hold", 32'(dout), 32'(exp_b));

      // reset colliding with a read frame
      step(1'b0, 1'b1, 10'h205);
      step(1'b1, 1'b1, 10'h300);
      chk("coll_tx", 32'(tx_valid), 32'd0);
      chk("coll_dout", 32'(dout), 32'd0);
      step(1'b0, 1'b1, 10'h300);
      chk("coll_tx2", 32'(tx_valid), 32'd0);
      chk("coll_err", 32'(err), 32'd1);

      // sweep: write i at address i, then back-to-back address/read pairs
      step(1'b1, 1'b0, 10'h000);
      for (int i = 0; i < 100; i++) begin
         step(1'b0, 1'b1, {2'b00, 8'(i)});
         step(1'b0, 1'b1, {2'b01, 8'(i)});
      end
      pulses = 0;
      for (int i = 0; i < 100; i++) begin
         step(1'b0, 1'b1, {2'b10, 8'(i)});
         if (tx_valid) pulses++;
         step(1'b0, 1'b1, 10'h300);
         if (tx_valid) pulses++;
         chk($sformatf("sweep%0d", i), 32'(dout), 32'(i));
      end
      step(1'b0, 1'b0, 10'h000);
      if (tx_valid) pulses++;
      chk("sweep_pulses", 32'(pulses), 32'd100);
      chk("sweep_err", 32'(err), 32'd0);

      // fill every location so random reads are always defined, then randomize against the model
      step(1'b1, 1'b0, 10'h000);
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b1, {2'b00, 8'(i)});
         step(1'b0, 1'b1, {2'b01, 8'($urandom)});
      end
      for (int n = 0; n < 2000; n++) begin
         logic r, v;
         logic [9:0] f;
         r = ($urandom_range(0, 63) == 0);
         v = ($urandom_range(0, 3) != 0);
         f = 10'($urandom);
         step(r, v, f);
         chk("rnd_tx",   32'(tx_valid), 32'(m_tx));
         chk("rnd_dout", 32'(dout),     32'(m_dout));
         chk("rnd_err",  32'(err),      32'(m_err));
      end

      // shallow instance: out-of-range loads flag err and keep the previous address
      s_step(1'b1, 1'b0, 10'h000);
      chk("s_rst_err", 32'(s_err), 32'd0);
      s_step(1'b0, 1'b1, 10'h010);
      s_step(1'b0, 1'b1, 10'h177);
      s_step(1'b0, 1'b1, 10'h090);
      chk("s_oor_wr_err", 32'(s_err), 32'd1);
      s_step(1'b0, 1'b1, 10'h188);
      s_step(1'b0, 1'b1, 10'h210);
      s_step(1'b0, 1'b1, 10'h300);
      chk("s_rd0_tx", 32'(s_tx_valid), 32'd1);
      chk("s_rd0", 32'(s_dout), AUTO ? 32'h77 : 32'h88);
      s_step(1'b0, 1'b1, 10'h280);
      s_step(1'b0, 1'b1, 10'h300);
      chk("s_rd1_tx", 32'(s_tx_valid), 32'd1);
      chk("s_rd1", 32'(s_dout), 32'h88);
      chk("s_err_sticky", 32'(s_err), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
